// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: buffer entry layout,
// LSU read/write encodings and the bit-mask merge used by buffer, array and forwarding.
package dm_pkg;

  localparam logic DM_READ  = 1'b1;
  localparam logic DM_WRITE = 1'b0;
  localparam int   WADDR_W  = 30;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [31:0]        data;
    logic [31:0]        mask;   // 1 = bit owned by this entry
    logic               valid;
  } wb_entry_t;

  function automatic logic [31:0] mask_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [31:0] m);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/dm_sram.sv
// Single-port word array: per-bit masked write, registered read that holds
// its value until the next read.
module dm_sram
  import dm_pkg::*;
#(
  parameter int AW    = 14,
  parameter int DEPTH = 16384
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [31:0]   i_wmask,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we)  r_mem[i_addr] <= mask_merge(r_mem[i_addr], i_wdata, i_wmask);
    if (i_en && !i_we) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// LSU-side data memory: 1-cycle loads, stores posted into a coalescing write
// buffer that drains to the array on idle cycles, plus a lower-priority ext port.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 16384,
  parameter int WB_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DM_c_en,
  input  logic                      DM_r_en,
  input  logic [31:0]               DM_w_en,
  input  logic [ADDR_W-1:0]         DM_addr,
  input  logic [31:0]               DM_w_data,
  output logic [31:0]               DM_rd_data,
  input  logic                      ext_valid,
  output logic                      ext_ready,
  input  logic                      ext_we,
  input  logic [ADDR_W-1:0]         ext_addr,
  input  logic [31:0]               ext_wdata,
  output logic                      ext_rvalid,
  output logic [31:0]               ext_rdata,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  localparam int AW = ADDR_W - 2;
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        r_wb [WB_DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic             r_rd_pend, r_ext_pend;
  logic [31:0]      r_fwd_data, r_fwd_mask, r_rd_hold, r_ext_hold;

  logic [WADDR_W-1:0] w_lsu_wa, w_ext_wa;
  logic               w_lsu_hit, w_ext_hit;
  logic [PW-1:0]      w_lsu_idx, w_ext_idx;
  logic               w_lsu_rd, w_lsu_wr, w_full, w_ext_coal, w_ext_fire, w_ext_arr;
  logic               w_ext_rd, w_ext_merge, w_drain, w_lsu_coal, w_alloc, w_same;
  logic [31:0]        w_lmask, w_base_data, w_base_mask, w_rd_merged;
  logic               w_sr_en, w_sr_we;
  logic [AW-1:0]      w_sr_addr;
  logic [31:0]        w_sr_wdata, w_sr_mask, w_sr_rdata;
  logic               w_unused;

  assign w_unused = ^{DM_addr[1:0], ext_addr[1:0]};
  assign w_lsu_wa = WADDR_W'(DM_addr[ADDR_W-1:2]);
  assign w_ext_wa = WADDR_W'(ext_addr[ADDR_W-1:2]);

  // CAM lookup; the coalescing invariant guarantees at most one hit per address
  always_comb begin
    w_lsu_hit = 1'b0;
    w_lsu_idx = '0;
    w_ext_hit = 1'b0;
    w_ext_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_wb[i].valid && r_wb[i].waddr == w_lsu_wa) begin
        w_lsu_hit = 1'b1;
        w_lsu_idx = PW'(i);
      end
      if (r_wb[i].valid && r_wb[i].waddr == w_ext_wa) begin
        w_ext_hit = 1'b1;
        w_ext_idx = PW'(i);
      end
    end
  end

  assign w_lsu_rd    = !DM_c_en && (DM_r_en == DM_READ);
  assign w_lsu_wr    = !DM_c_en && (DM_r_en == DM_WRITE);
  assign w_full      = (r_count == CW'(WB_DEPTH));
  assign w_ext_coal  = ext_we && w_ext_hit;
  assign ext_ready   = rst && !w_lsu_rd && (!w_full || w_ext_coal);
  assign w_ext_fire  = ext_valid && ext_ready;
  assign w_ext_arr   = w_ext_fire && !w_ext_coal;
  assign w_ext_rd    = w_ext_fire && !ext_we;
  assign w_ext_merge = w_ext_fire && w_ext_coal;
  assign w_drain     = rst && (r_count != '0) && !w_lsu_rd && !w_ext_arr;
  // a store never joins the entry leaving this cycle; it allocates behind it instead
  assign w_lsu_coal  = w_lsu_wr && w_lsu_hit && !(w_drain && w_lsu_idx == r_head);
  assign w_alloc     = w_lsu_wr && !w_lsu_coal;
  assign w_lmask     = ~DM_w_en;
  assign w_same      = w_ext_merge && w_lsu_coal && (w_ext_idx == w_lsu_idx);
  assign w_base_data = w_same ? ext_wdata : r_wb[w_lsu_idx].data;
  assign w_base_mask = w_same ? '1 : r_wb[w_lsu_idx].mask;

  always_comb begin
    w_sr_en    = 1'b0;
    w_sr_we    = 1'b0;
    w_sr_addr  = w_lsu_wa[AW-1:0];
    w_sr_wdata = r_wb[r_head].data;
    w_sr_mask  = r_wb[r_head].mask;
    if (w_lsu_rd) begin
      w_sr_en = 1'b1;
    end else if (w_ext_arr) begin
      w_sr_en    = 1'b1;
      w_sr_we    = ext_we;
      w_sr_addr  = w_ext_wa[AW-1:0];
      w_sr_wdata = ext_wdata;
      w_sr_mask  = '1;
    end else if (w_drain) begin
      w_sr_en   = 1'b1;
      w_sr_we   = 1'b1;
      w_sr_addr = r_wb[r_head].waddr[AW-1:0];
      // ext write landing on the departing head goes out with it
      if (w_ext_merge && w_ext_idx == r_head) begin
        w_sr_wdata = ext_wdata;
        w_sr_mask  = '1;
      end
    end
  end

  dm_sram #(.AW(AW), .DEPTH(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .i_en    (w_sr_en),
    .i_we    (w_sr_we),
    .i_addr  (w_sr_addr),
    .i_wdata (w_sr_wdata),
    .i_wmask (w_sr_mask),
    .o_rdata (w_sr_rdata)
  );

  // ext update first, LSU store last so the younger store wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_DEPTH; i++) r_wb[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) begin
        r_wb[r_head].valid <= 1'b0;
        r_head             <= r_head + PW'(1);
      end
      if (w_ext_merge && !(w_drain && w_ext_idx == r_head)) begin
        r_wb[w_ext_idx].data <= ext_wdata;
        r_wb[w_ext_idx].mask <= '1;
      end
      if (w_lsu_coal) begin
        r_wb[w_lsu_idx].data <= mask_merge(w_base_data, DM_w_data, w_lmask);
        r_wb[w_lsu_idx].mask <= w_base_mask | w_lmask;
      end
      if (w_alloc) begin
        r_wb[r_tail] <= '{waddr: w_lsu_wa, data: DM_w_data, mask: w_lmask, valid: 1'b1};
        r_tail       <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend  <= 1'b0;
      r_ext_pend <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
      r_rd_hold  <= '0;
      r_ext_hold <= '0;
    end else begin
      r_rd_pend  <= w_lsu_rd;
      r_ext_pend <= w_ext_rd;
      if (w_lsu_rd) begin
        r_fwd_data <= r_wb[w_lsu_idx].data;
        r_fwd_mask <= w_lsu_hit ? r_wb[w_lsu_idx].mask : '0;
      end else if (w_ext_rd) begin
        r_fwd_data <= r_wb[w_ext_idx].data;
        r_fwd_mask <= w_ext_hit ? r_wb[w_ext_idx].mask : '0;
      end
      if (r_rd_pend)  r_rd_hold  <= w_rd_merged;
      if (r_ext_pend) r_ext_hold <= w_rd_merged;
    end
  end

  assign w_rd_merged = mask_merge(w_sr_rdata, r_fwd_data, r_fwd_mask);
  assign DM_rd_data  = r_rd_pend ? w_rd_merged : r_rd_hold;
  assign ext_rdata   = r_ext_pend ? w_rd_merged : r_ext_hold;
  assign ext_rvalid  = r_ext_pend;
  assign wb_count    = r_count;

endmodule
